// File: rtl/subservient_gpio_bank.sv
// WIDTH-channel GPIO bank on the subservient peripheral Wishbone port: per-bit direction,
// input synchronisers, rising-edge capture into write-1-to-clear pending bits, level irq.
module subservient_gpio_bank #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    typedef enum logic [1:0] {
        RegData = 2'd0,
        RegDir  = 2'd1,
        RegIe   = 2'd2,
        RegIp   = 2'd3
    } reg_e;

    logic [31:0]      r_rdt;
    logic             r_ack;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_ie;
    logic [WIDTH-1:0] r_ip;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];

    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    reg_e             w_reg;
    logic [31:0]      w_wmask;
    logic [31:0]      w_wbits;
    logic [WIDTH-1:0] w_lmask;
    logic [WIDTH-1:0] w_lbits;
    logic [WIDTH-1:0] w_sync_in;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_out_d;
    logic [WIDTH-1:0] w_dir_d;
    logic [WIDTH-1:0] w_ie_d;
    logic [WIDTH-1:0] w_ip_clr;
    logic [WIDTH-1:0] w_ip_d;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // A strobe is accepted only while ack is low, so each access takes two cycles.
    assign w_req = i_wb_stb & ~r_ack;
    assign w_wr  = w_req & i_wb_we;
    assign w_rd  = w_req & ~i_wb_we;
    assign w_reg = reg_e'(i_wb_adr[3:2]);

    always_comb begin
        w_wmask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
        w_wbits = i_wb_dat & w_wmask;
    end

    assign w_lmask = w_wmask[WIDTH-1:0];
    assign w_lbits = w_wbits[WIDTH-1:0];

    assign w_sync_in = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_sync_in & ~r_prev;

    always_comb begin
        w_out_d  = r_out;
        w_dir_d  = r_dir;
        w_ie_d   = r_ie;
        w_ip_clr = '0;
        if (w_wr) begin
            case (w_reg)
                RegData: w_out_d  = (r_out & ~w_lmask) | w_lbits;
                RegDir:  w_dir_d  = (r_dir & ~w_lmask) | w_lbits;
                RegIe:   w_ie_d   = (r_ie & ~w_lmask) | w_lbits;
                RegIp:   w_ip_clr = w_lbits;
                default: ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit pending.
        w_ip_d = (r_ip & ~w_ip_clr) | (w_rise & r_ie);
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            RegData: w_rdata[WIDTH-1:0] = (r_dir & r_out) | (~r_dir & w_sync_in);
            RegDir:  w_rdata[WIDTH-1:0] = r_dir;
            RegIe:   w_rdata[WIDTH-1:0] = r_ie;
            RegIp:   w_rdata[WIDTH-1:0] = r_ip;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack <= 1'b0;
            r_rdt <= '0;
        end else begin
            r_ack <= w_req;
            if (w_rd) begin
                r_rdt <= w_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
            r_dir <= '0;
            r_ie  <= '0;
            r_ip  <= '0;
        end else begin
            r_out <= w_out_d;
            r_dir <= w_dir_d;
            r_ie  <= w_ie_d;
            r_ip  <= w_ip_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= i_gpio;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_in;
        end
    end

    assign o_wb_ack  = r_ack;
    assign o_wb_rdt  = r_rdt;
    assign o_gpio    = r_out;
    assign o_gpio_oe = r_dir;
    assign o_irq     = |r_ip;

    // Address bits outside [3:2] and data lanes above WIDTH are deliberately ignored.
    assign w_unused = ^{i_wb_adr[31:4], i_wb_adr[1:0], w_wmask, w_wbits};

endmodule

// File: tb/tb_subservient_gpio_bank.sv
// Directed bench for subservient_gpio_bank: vector table for register access plus hand-timed
// sequences for reset abort, synchroniser latency, interrupt capture and set-vs-clear.
module tb_subservient_gpio_bank;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_DIR  = 2'd1;
    localparam logic [1:0] A_IE   = 2'd2;
    localparam logic [1:0] A_IP   = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        stb8 = 1'b0;
    logic        stb32 = 1'b0;
    logic [31:0] rdt8;
    logic [31:0] rdt32;
    logic        ack8;
    logic        ack32;
    logic [7:0]  pads8 = '0;
    logic [31:0] pads32 = '0;
    logic [7:0]  gpio8;
    logic [7:0]  oe8;
    logic [31:0] gpio32;
    logic [31:0] oe32;
    logic        irq8;
    logic        irq32;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    subservient_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wb_adr  (wb_adr),
        .i_wb_dat  (wb_dat),
        .i_wb_sel  (wb_sel),
        .i_wb_we   (wb_we),
        .i_wb_stb  (stb8),
        .o_wb_rdt  (rdt8),
        .o_wb_ack  (ack8),
        .i_gpio    (pads8),
        .o_gpio    (gpio8),
        .o_gpio_oe (oe8),
        .o_irq     (irq8)
    );

    subservient_gpio_bank #(.WIDTH(32), .SYNC_STAGES(2)) u_dut32 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wb_adr  (wb_adr),
        .i_wb_dat  (wb_dat),
        .i_wb_sel  (wb_sel),
        .i_wb_we   (wb_we),
        .i_wb_stb  (stb32),
        .o_wb_rdt  (rdt32),
        .o_wb_ack  (ack32),
        .i_gpio    (pads32),
        .o_gpio    (gpio32),
        .o_gpio_oe (oe32),
        .o_irq     (irq32)
    );

    typedef struct {
        logic        we;
        logic [1:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rdt;
        logic [7:0]  exp_gpio;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller sits just after a rising edge; returns one cycle after the ack edge.
    task automatic wb(input bit big, input logic we, input logic [1:0] rsel,
                      input logic [31:0] dat, input logic [3:0] sel, output logic [31:0] rdt);
        bit got;
        got = 1'b0;
        wb_adr = {28'h0, rsel, 2'b00};
        wb_dat = dat;
        wb_sel = sel;
        wb_we  = we;
        if (big) stb32 = 1'b1;
        else     stb8  = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if ((big ? ack32 : ack8) === 1'b1) got = 1'b1;
        end
        stb8  = 1'b0;
        stb32 = 1'b0;
        rdt   = big ? rdt32 : rdt8;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack within 8 cycles");
        end
        @(posedge clk); #1;
        chk("ack_pulse", {31'b0, (big ? ack32 : ack8)}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;

        vecs[0]  = '{1'b1, A_DIR,  32'h0000_00FF, 4'h1, 32'h0,  8'h00, 8'hFF};
        vecs[1]  = '{1'b1, A_DATA, 32'h0000_00A5, 4'h1, 32'h0,  8'hA5, 8'hFF};
        vecs[2]  = '{1'b0, A_DATA, 32'h0,         4'h0, 32'hA5, 8'hA5, 8'hFF};
        vecs[3]  = '{1'b0, A_DIR,  32'h0,         4'h0, 32'hFF, 8'hA5, 8'hFF};
        vecs[4]  = '{1'b1, A_DATA, 32'hFFFF_FF3C, 4'h0, 32'h0,  8'hA5, 8'hFF};
        vecs[5]  = '{1'b0, A_DATA, 32'h0,         4'hF, 32'hA5, 8'hA5, 8'hFF};
        vecs[6]  = '{1'b1, A_IE,   32'hFFFF_FFFF, 4'hF, 32'h0,  8'hA5, 8'hFF};
        vecs[7]  = '{1'b0, A_IE,   32'h0,         4'h0, 32'hFF, 8'hA5, 8'hFF};
        vecs[8]  = '{1'b1, A_IE,   32'h0,         4'hF, 32'h0,  8'hA5, 8'hFF};
        vecs[9]  = '{1'b0, A_IE,   32'h0,         4'h0, 32'h00, 8'hA5, 8'hFF};
        vecs[10] = '{1'b1, A_DIR,  32'h0000_000F, 4'h1, 32'h0,  8'hA5, 8'h0F};
        vecs[11] = '{1'b0, A_DATA, 32'h0,         4'h0, 32'h05, 8'hA5, 8'h0F};
        vecs[12] = '{1'b1, A_DIR,  32'h0,         4'h1, 32'h0,  8'hA5, 8'h00};
        vecs[13] = '{1'b1, A_DATA, 32'h0000_005A, 4'h1, 32'h0,  8'h5A, 8'h00};
        vecs[14] = '{1'b0, A_DATA, 32'h0,         4'h0, 32'h00, 8'h5A, 8'h00};
        vecs[15] = '{1'b0, A_IP,   32'h0,         4'h0, 32'h00, 8'h5A, 8'h00};
        vecs[16] = '{1'b1, A_DIR,  32'hFFFF_FF00, 4'hF, 32'h0,  8'h5A, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset lands between strobe and its would-be ack edge.
        wb_adr = {28'h0, A_DIR, 2'b00};
        wb_dat = 32'hFF;
        wb_sel = 4'hF;
        wb_we  = 1'b1;
        stb8   = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack_in_reset", {31'b0, ack8}, 32'h0);
        @(posedge clk); #1;
        stb8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ack_after", {31'b0, ack8}, 32'h0);
        chk("rst_gpio", {24'h0, gpio8}, 32'h0);
        chk("rst_oe", {24'h0, oe8}, 32'h0);
        chk("rst_irq", {31'b0, irq8}, 32'h0);
        chk("rst_rdt", rdt8, 32'h0);
        for (int r = 0; r < 4; r++) begin
            wb(1'b0, 1'b0, 2'(r), 32'h0, 4'h0, rd);
            chk($sformatf("rst_read_reg%0d", r), rd, 32'h0);
        end

        for (int i = 0; i < 17; i++) begin
            wb(1'b0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdt", i), rd, vecs[i].exp_rdt);
            chk($sformatf("vec%0d_gpio", i), {24'h0, gpio8}, {24'h0, vecs[i].exp_gpio});
            chk($sformatf("vec%0d_oe", i), {24'h0, oe8}, {24'h0, vecs[i].exp_oe});
        end

        // Byte lanes on the 32-bit instance.
        wb(1'b1, 1'b1, A_DATA, 32'h1234_5678, 4'b0101, rd);
        chk("lanes_gpio_0101", gpio32, 32'h0034_0078);
        wb(1'b1, 1'b1, A_DIR, 32'hFFFF_FFFF, 4'hF, rd);
        chk("lanes_oe32", oe32, 32'hFFFF_FFFF);
        wb(1'b1, 1'b1, A_DATA, 32'hAABB_CCDD, 4'b1010, rd);
        wb(1'b1, 1'b0, A_DATA, 32'h0, 4'h0, rd);
        chk("lanes_read_1010", rd, 32'hAA34_CC78);

        // Synchroniser: a read captured one edge too early still sees the old pad value.
        pads8 = 8'h3C;
        @(posedge clk); #1;
        wb(1'b0, 1'b0, A_DATA, 32'h0, 4'h0, rd);
        chk("sync_early_read", rd, 32'h00);
        pads8 = 8'hC3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb(1'b0, 1'b0, A_DATA, 32'h0, 4'h0, rd);
        chk("sync_read", rd, 32'hC3);

        pads8 = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        wb(1'b0, 1'b1, A_IE, 32'h01, 4'h1, rd);
        pads8 = 8'h01;
        @(posedge clk); #1;
        chk("irq_edge1", {31'b0, irq8}, 32'h0);
        @(posedge clk); #1;
        chk("irq_edge2", {31'b0, irq8}, 32'h0);
        @(posedge clk); #1;
        chk("irq_edge3", {31'b0, irq8}, 32'h1);
        wb(1'b0, 1'b0, A_IP, 32'h0, 4'h0, rd);
        chk("ip_after_rise0", rd, 32'h01);

        pads8 = 8'h03;
        repeat (5) @(posedge clk);
        #1;
        wb(1'b0, 1'b0, A_IP, 32'h0, 4'h0, rd);
        chk("ip_masked_rise1", rd, 32'h01);
        wb(1'b0, 1'b1, A_IP, 32'hFFFF_FFFE, 4'hF, rd);
        wb(1'b0, 1'b0, A_IP, 32'h0, 4'h0, rd);
        chk("ip_w0_no_effect", rd, 32'h01);
        wb(1'b0, 1'b1, A_IE, 32'h00, 4'h1, rd);
        chk("irq_ie_cleared", {31'b0, irq8}, 32'h1);
        wb(1'b0, 1'b1, A_IP, 32'h01, 4'h1, rd);
        chk("irq_after_w1c", {31'b0, irq8}, 32'h0);
        wb(1'b0, 1'b0, A_IP, 32'h0, 4'h0, rd);
        chk("ip_after_w1c", rd, 32'h00);

        // Set-vs-clear: arm IP[0], then land a W1C on the edge that captures a new rise.
        wb(1'b0, 1'b1, A_IE, 32'h01, 4'h1, rd);
        pads8 = 8'h02;
        repeat (4) @(posedge clk);
        #1;
        pads8 = 8'h03;
        repeat (3) @(posedge clk);
        #1;
        chk("irq_rearmed", {31'b0, irq8}, 32'h1);
        pads8 = 8'h02;
        repeat (4) @(posedge clk);
        #1;
        pads8 = 8'h03;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb(1'b0, 1'b1, A_IP, 32'h01, 4'h1, rd);
        chk("collide_irq", {31'b0, irq8}, 32'h1);
        wb(1'b0, 1'b0, A_IP, 32'h0, 4'h0, rd);
        chk("collide_ip", rd, 32'h01);
        wb(1'b0, 1'b1, A_IP, 32'h01, 4'h1, rd);
        chk("final_clear_irq", {31'b0, irq8}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/subservient_gpio_bank.md
Name: subservient_gpio_bank

Overview:
Parametrised successor to the single-bit subservient GPIO peripheral. It provides WIDTH independent I/O channels with per-bit direction, input synchronisers, rising-edge interrupt capture and a level interrupt output. It sits on the subservient core's peripheral Wishbone port (32-bit data, stb/ack, no cyc), replacing the 1-bit GPIO in the SoC toplevel.

Parameters:
WIDTH, 8, number of GPIO channels; legal range 1..32.
SYNC_STAGES, 2, flops in each input synchroniser; legal range 2 or more.

Ports:
i_clk  input  1  system clock; all flops rise-edge.
i_rst_n  input  1  asynchronous active-low reset.
i_wb_adr  input  32  word address; only bits [3:2] are decoded.
i_wb_dat  input  32  write data.
i_wb_sel  input  4  byte-lane write enables.
i_wb_we  input  1  1 = write, 0 = read.
i_wb_stb  input  1  request strobe; held by the master until ack.
o_wb_rdt  output  32  read data, registered.
o_wb_ack  output  1  single-cycle acknowledge, registered.
i_gpio  input  WIDTH  asynchronous pad inputs.
o_gpio  output  WIDTH  output data register.
o_gpio_oe  output  WIDTH  output enable; equals DIR.
o_irq  output  1  OR of all IP bits.

Behaviour:
- Reset (i_rst_n low, asynchronous): OUT=0, DIR=0, IE=0, IP=0, all sync flops=0, edge-history flops=0, o_wb_ack=0, o_wb_rdt=0. Hence o_gpio=0, o_gpio_oe=0, o_irq=0.
- Reset asserted mid-transaction aborts it. No ack is issued. After release, the master must re-present stb.
- Register map by adr[3:2]:
  - 0 DATA: write sets OUT. Read returns bit i = DIR[i] ? OUT[i] : sync_in[i].
  - 1 DIR: read/write; 1 = output.
  - 2 IE: read/write; per-bit interrupt enable.
  - 3 IP: read returns pending bits. Write-1-to-clear; writing 0 has no effect.
- Bits [31:WIDTH] read as 0 and ignore writes.
- Byte lanes: a write affects bits [8k+7:8k] only where i_wb_sel[k]=1. Reads ignore sel.
- Handshake:
  - When i_wb_stb=1 and o_wb_ack=0, the next edge sets o_wb_ack=1 for exactly one cycle.
  - On that same edge the write is committed, or o_wb_rdt is loaded.
  - Because ack is forced low for at least one cycle between accesses, back-to-back strobes complete every 2 cycles.
  - o_wb_rdt holds its value until the next read; it is not cleared on writes.
- Synchroniser: sync_in = i_gpio delayed through SYNC_STAGES flops. A pad change is visible in a DATA read issued SYNC_STAGES cycles later.
- Edge detect: prev <= sync_in every cycle. rise[i] = sync_in[i] & ~prev[i].
  - IP[i] sets when rise[i] & IE[i]; this lands SYNC_STAGES+1 edges after the pad change.
  - The edge is detected regardless of DIR.
- Simultaneous new edge and W1C on the same bit in the same cycle: set wins, and IP stays 1.
- Clearing IE does not clear IP.
- o_irq = |IP, driven directly from registers with no extra latency.
- A pad held high through reset release produces a rise after SYNC_STAGES cycles. It is ignored because IE=0 at reset.
- Writes to DATA while DIR=0 still update OUT. The value is driven once DIR is set.

Test Plan:
- Reset/readback: assert i_rst_n=0 mid-write to DIR, then release → no ack seen; DATA, DIR, IE and IP all read 0; o_gpio=0, o_gpio_oe=0, o_irq=0.
- Output path: write DIR=0xFF, then DATA=0xA5 (sel=4'b0001) → o_gpio=0xA5 and o_gpio_oe=0xFF on the ack edge; DATA reads 0xA5; each ack high for exactly 1 cycle.
- Byte lanes, WIDTH=32: write DATA=0x12345678 with sel=4'b0101 onto OUT=0 → OUT=0x00340078; bits above WIDTH read 0 for WIDTH=8.
- Input sync: DIR=0, i_gpio 0x00→0x3C → DATA read returns 0x3C only from SYNC_STAGES cycles after the change.
- Interrupt: IE=0x01, pulse i_gpio[0] 0→1 → IP=0x01 and o_irq=1 at SYNC_STAGES+1 edges; a rise on bit 1 (IE=0) leaves IP unchanged; W1C IP=0x01 → o_irq=0.
- Set-vs-clear collision: time a W1C of IP[0] onto the same edge as a new rise on bit 0 → IP[0] remains 1 and o_irq stays 1.
